uart_tx_buffered: RTL

Buffered, single-clock UART transmitter for the tester's serial channels. It sits between the command/register logic and the tx pin. A parametrised FIFO decouples word pushes from line timing. Frames run back-to-back with configurable data width, parity and stop bits, all derived from one clock-enable baud tick. Optional break generation is available for line-reset sequences.

---
 rtl/uart_tx_buffered.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered UART transmitter; optional break/guard under UART_TX_BREAK_EN
module uart_tx_buffered #(
  parameter int CLOCK_DIVISOR_WIDTH = 24,
  parameter int DATA_WIDTH          = 8,
  parameter int FIFO_DEPTH_LOG2     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           tx,
  input  logic [3:0]                     dataBits,
  input  logic                           hasParity,
  input  logic [1:0]                     parityMode,
  input  logic                           extraStopBit,
  input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
  input  logic [DATA_WIDTH-1:0]          data,
  input  logic                           transmitReq,
  output logic                           ready,
  output logic [FIFO_DEPTH_LOG2:0]       fifoLevel,
  output logic                           busy,
  input  logic                           breakReq
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
`ifdef UART_TX_BREAK_EN
    S_STOP,
    S_BREAK,
    S_GUARD
`else
    S_STOP
`endif
  } state_t;

  state_t state, state_n;

  logic [DATA_WIDTH-1:0]          mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0]     wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]       level;
  logic                           push, pop, empty;

  logic [CLOCK_DIVISOR_WIDTH-1:0] baud_cnt, ctx_div;
  logic [4:0]                     bit_cnt, ctx_nbits, req_nbits;
  logic                           ctx_par_en, ctx_par_bit, ctx_two_stop, stop_second;
  logic [DATA_WIDTH-1:0]          shreg, head_word, head_masked;
  logic                           head_par;
  logic                           tick, baud_run, guard_start;

  assign empty     = (level == '0);
  assign ready     = ~level[FIFO_DEPTH_LOG2];
  assign push      = transmitReq & ready;
  assign fifoLevel = level;
  assign busy      = (state != S_IDLE) | ~empty;
  assign tick      = (baud_cnt == ctx_div);
  assign head_word = mem[rd_ptr];
  assign req_nbits = (({1'b0, dataBits} + 5'd1) > 5'(DATA_WIDTH)) ? 5'(DATA_WIDTH)
                                                                  : ({1'b0, dataBits} + 5'd1);

`ifdef UART_TX_BREAK_EN
  assign baud_run = (state != S_IDLE) && (state != S_BREAK);
`else
  assign baud_run = (state != S_IDLE);
  logic unused_break;
  assign unused_break = breakReq;
`endif

  // Parity covers only the n data bits that will actually be shifted out
  always_comb begin
    head_masked = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (i < int'(req_nbits)) head_masked[i] = head_word[i];
    case (parityMode)
      2'b00:   head_par = 1'b0;
      2'b01:   head_par = ~(^head_masked);
      2'b10:   head_par = ^head_masked;
      default: head_par = 1'b1;
    endcase
  end

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // FSM next state; frame boundaries decide between break, next frame and idle
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    guard_start = 1'b0;
    case (state)
      S_IDLE: begin
`ifdef UART_TX_BREAK_EN
        if (breakReq) state_n = S_BREAK;
        else
`endif
        if (!empty) begin
          pop     = 1'b1;
          state_n = S_START;
        end
      end
      S_START: if (tick) state_n = S_DATA;
      S_DATA:  if (tick && (bit_cnt == ctx_nbits - 5'd1)) state_n = ctx_par_en ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_n = S_STOP;
      S_STOP: begin
        if (tick && (stop_second || !ctx_two_stop)) begin
`ifdef UART_TX_BREAK_EN
          if (breakReq) state_n = S_BREAK;
          else
`endif
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
`ifdef UART_TX_BREAK_EN
      S_BREAK: begin
        if (!breakReq) begin
          state_n     = S_GUARD;
          guard_start = 1'b1;
        end
      end
      S_GUARD: begin
        if (tick) begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase
  end

  // Frame context latch at pop, baud counter and bit shifting
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      ctx_div      <= '0;
      ctx_nbits    <= '0;
      ctx_par_en   <= 1'b0;
      ctx_par_bit  <= 1'b0;
      ctx_two_stop <= 1'b0;
      stop_second  <= 1'b0;
    end else if (pop) begin
      shreg        <= head_word;
      ctx_div      <= clockDivisor;
      ctx_nbits    <= req_nbits;
      ctx_par_en   <= hasParity;
      ctx_par_bit  <= head_par;
      ctx_two_stop <= extraStopBit;
      baud_cnt     <= '0;
      bit_cnt      <= '0;
      stop_second  <= 1'b0;
    end else if (guard_start) begin
      ctx_div  <= clockDivisor;
      baud_cnt <= '0;
    end else if (baud_run) begin
      if (tick) begin
        baud_cnt <= '0;
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 5'd1;
        end
        if (state == S_STOP) stop_second <= 1'b1;
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  // Line level decoded from state and shift register
  always_comb begin
    tx = 1'b1;
    case (state)
      S_START: tx = 1'b0;
      S_DATA:  tx = shreg[0];
      S_PAR:   tx = ctx_par_bit;
`ifdef UART_TX_BREAK_EN
      S_BREAK: tx = 1'b0;
`endif
      default: tx = 1'b1;
    endcase
  end
endmodule
